sram_axi_arbiter: RTL and testbench

Shares one AXI master port between the CPU's SRAM-like instruction port (read-only) and data port (read/write). Sits between the core's inst_sram/data_sram interfaces and the AXI interconnect. Only one transaction is outstanding at a time, so no AXI IDs are needed. The block generates the addr_ok/data_ok handshakes that the IF and MEM stages stall on.

---
 rtl/sram_axi_arbiter_pkg.sv | 20 ++
 rtl/sram_axi_arbiter_wstrb.sv | 21 ++
 rtl/sram_axi_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_sram_axi_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_axi_arbiter_pkg.sv
// Shared encodings for the SRAM-to-AXI arbiter: FSM states, transfer size codes
// and request-owner identifiers.
package sram_axi_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE = 3'd0,
        ARB_AR   = 3'd1,
        ARB_R    = 3'd2,
        ARB_WR   = 3'd3,
        ARB_B    = 3'd4
    } arb_state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

endpackage

// File: rtl/sram_axi_arbiter_wstrb.sv
// Byte-lane strobe generator: maps transfer size and the low address bits to
// the AXI write strobes.
module sram_wstrb_gen
    import sram_axi_arbiter_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] wstrb
);

    // Lane selection per transfer size
    always_comb begin
        case (size)
            SIZE_B:  wstrb = 4'b0001 << addr_lo;
            SIZE_H:  wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  wstrb = 4'b1111;
            default: wstrb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/sram_axi_arbiter.sv
// Shares one AXI master between the instruction (read-only) and data SRAM-like
// ports; a single transaction is outstanding at any time.
module sram_axi_arbiter
    import sram_axi_arbiter_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    arb_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        owner_q, owner_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic        grant_data_s;
    logic        grant_inst_s;
    logic        r_hs_s;
    logic        aw_fin_s;
    logic        w_fin_s;

    assign grant_data_s = (state_q == ARB_IDLE) && data_req && (DATA_FIRST || !inst_req);
    assign grant_inst_s = (state_q == ARB_IDLE) && inst_req && !grant_data_s;
    assign r_hs_s       = (state_q == ARB_R) && rvalid;
    // A channel counts as finished if it completed earlier or handshakes now
    assign aw_fin_s     = aw_done_q || (awvalid_q && awready);
    assign w_fin_s      = w_done_q || (wvalid_q && wready);

    assign inst_addr_ok = grant_inst_s;
    assign data_addr_ok = grant_data_s;
    assign inst_data_ok = r_hs_s && (owner_q == OWNER_INST);
    assign data_data_ok = (r_hs_s && (owner_q == OWNER_DATA)) || ((state_q == ARB_B) && bvalid);
    assign inst_rdata   = inst_data_ok ? rdata : 32'h0000_0000;
    assign data_rdata   = (r_hs_s && (owner_q == OWNER_DATA)) ? rdata : 32'h0000_0000;

    assign araddr  = addr_q;
    assign arsize  = {1'b0, size_q};
    assign arvalid = arvalid_q;
    assign rready  = rready_q;
    assign awaddr  = addr_q;
    assign awsize  = {1'b0, size_q};
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

    sram_wstrb_gen u_wstrb (
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .wstrb   (wstrb)
    );

    // Next-state and next-output computation for the transaction FSM
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        owner_d   = owner_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_data_s) begin
                    addr_d  = data_addr;
                    size_d  = data_size;
                    wdata_d = data_wdata;
                    owner_d = OWNER_DATA;
                    if (data_wr) begin
                        state_d   = ARB_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = ARB_AR;
                        arvalid_d = 1'b1;
                    end
                end else if (grant_inst_s) begin
                    addr_d    = inst_addr;
                    size_d    = SIZE_W;
                    wdata_d   = 32'h0000_0000;
                    owner_d   = OWNER_INST;
                    state_d   = ARB_AR;
                    arvalid_d = 1'b1;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_AR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ARB_R;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            ARB_R: begin
                if (rvalid) begin
                    rready_d = 1'b0;
                    state_d  = ARB_IDLE;
                end else begin
                    rready_d = 1'b1;
                end
            end
            ARB_WR: begin
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end else begin
                    awvalid_d = awvalid_q;
                end
                if (wvalid_q && wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end else begin
                    wvalid_d = wvalid_q;
                end
                if (aw_fin_s && w_fin_s) begin
                    bready_d = 1'b1;
                    state_d  = ARB_B;
                end else begin
                    bready_d = 1'b0;
                end
            end
            ARB_B: begin
                if (bvalid) begin
                    bready_d = 1'b0;
                    state_d  = ARB_IDLE;
                end else begin
                    bready_d = 1'b1;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
            end
        endcase
    end

    // State and registered-output flops; reset abandons any open transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            addr_q    <= 32'h0000_0000;
            size_q    <= 2'd0;
            wdata_q   <= 32'h0000_0000;
            owner_q   <= OWNER_INST;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            owner_q   <= owner_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Self-checking bench: a transaction-level model of the arbiter is compared
// with the DUT every cycle, under directed scenarios and random traffic.
module tb_sram_axi_arbiter;

    localparam bit DF = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    sram_axi_arbiter #(.DATA_FIRST(DF)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the one transaction currently in flight, if any
    bit          m_busy, m_is_data, m_wr, m_ar_done, m_aw_done, m_w_done;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_size;

    bit e_gd, e_gi, e_ar, e_rr, e_aw, e_w, e_b, e_idok, e_ddok;
    bit acc_i, acc_d, pend_i, pend_d;
    int       dok_cnt;
    bit [7:0] dok_seq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte mask of 2^size bytes at the size-aligned lane offset
    function automatic logic [3:0] exp_strb(input logic [1:0] size, input logic [31:0] addr);
        int bytes;
        int offs;
        bytes = 1 << size;
        offs  = int'(addr[1:0]) & ~(bytes - 1);
        return 4'(((1 << bytes) - 1) << offs);
    endfunction

    task automatic clr();
        inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0; data_wdata = 32'h0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    endtask

    task automatic sample();
        #1;
        e_gd   = !m_busy && data_req && (DF || !inst_req);
        e_gi   = !m_busy && inst_req && !e_gd;
        e_ar   = m_busy && !m_wr && !m_ar_done;
        e_rr   = m_busy && !m_wr && m_ar_done;
        e_aw   = m_busy && m_wr && !m_aw_done;
        e_w    = m_busy && m_wr && !m_w_done;
        e_b    = m_busy && m_wr && m_aw_done && m_w_done;
        e_idok = e_rr && rvalid && !m_is_data;
        e_ddok = (e_rr && rvalid && m_is_data) || (e_b && bvalid);
        chk("inst_addr_ok", inst_addr_ok, e_gi);
        chk("data_addr_ok", data_addr_ok, e_gd);
        chk("arvalid", arvalid, e_ar);
        chk("rready", rready, e_rr);
        chk("awvalid", awvalid, e_aw);
        chk("wvalid", wvalid, e_w);
        chk("bready", bready, e_b);
        chk("inst_data_ok", inst_data_ok, e_idok);
        chk("data_data_ok", data_data_ok, e_ddok);
        if (e_ar) begin
            chk("araddr", araddr, m_addr);
            chk("arsize", arsize, {1'b0, m_size});
        end
        if (e_aw || e_w) begin
            chk("awaddr", awaddr, m_addr);
            chk("awsize", awsize, {1'b0, m_size});
            chk("wdata", wdata, m_wdata);
            chk("wstrb", wstrb, exp_strb(m_size, m_addr));
        end
        if (e_idok) begin
            chk("inst_rdata", inst_rdata, rdata);
            chk("data_rdata_idle", data_rdata, 32'h0);
        end
        if (e_ddok && !m_wr) begin
            chk("data_rdata", data_rdata, rdata);
            chk("inst_rdata_idle", inst_rdata, 32'h0);
        end
    endtask

    task automatic advance();
        acc_i = 1'b0;
        acc_d = 1'b0;
        if (reset) begin
            m_busy = 1'b0;
        end else begin
            if (e_idok || e_ddok) begin
                dok_cnt++;
                dok_seq = {dok_seq[6:0], e_ddok};
            end
            if (!m_busy) begin
                if (e_gd) begin
                    m_busy = 1'b1; m_is_data = 1'b1; m_wr = data_wr; m_addr = data_addr;
                    m_size = data_size; m_wdata = data_wdata; acc_d = 1'b1;
                    m_ar_done = 1'b0; m_aw_done = 1'b0; m_w_done = 1'b0;
                end else if (e_gi) begin
                    m_busy = 1'b1; m_is_data = 1'b0; m_wr = 1'b0; m_addr = inst_addr;
                    m_size = 2'd2; m_wdata = 32'h0; acc_i = 1'b1;
                    m_ar_done = 1'b0; m_aw_done = 1'b0; m_w_done = 1'b0;
                end
            end else if (!m_wr) begin
                if (!m_ar_done) begin
                    if (arready) m_ar_done = 1'b1;
                end else if (rvalid) begin
                    m_busy = 1'b0;
                end
            end else if (m_aw_done && m_w_done) begin
                if (bvalid) m_busy = 1'b0;
            end else begin
                if (awready) m_aw_done = 1'b1;
                if (wready) m_w_done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_slave(input bit rnd);
        arready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        awready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        wready  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        rvalid  = m_busy && !m_wr && m_ar_done && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
        bvalid  = m_busy && m_wr && m_aw_done && m_w_done && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
        rdata   = $urandom;
    endtask

    // Acts as an always-ready slave until everything requested has completed
    task automatic serve(input int max_cycles);
        for (int i = 0; i < max_cycles && (m_busy || inst_req || data_req); i++) begin
            drive_slave(1'b0);
            sample();
            advance();
            if (acc_i) inst_req = 1'b0;
            if (acc_d) data_req = 1'b0;
        end
        clr();
        chk("serve_done", {31'h0, m_busy || inst_req || data_req}, 32'h0);
    endtask

    initial begin
        clr();
        reset = 1'b1;
        m_busy = 1'b0;
        dok_cnt = 0;
        dok_seq = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        sample();
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_bready", bready, 1'b0);
        advance();
        reset = 1'b0;

        // Instruction read alone
        inst_req = 1'b1; inst_addr = 32'hbfc0_0000;
        sample();
        chk("t1_addr_ok", inst_addr_ok, 1'b1);
        advance();
        inst_req = 1'b0; arready = 1'b1;
        sample();
        chk("t1_araddr", araddr, 32'hbfc0_0000);
        chk("t1_arsize", arsize, 3'd2);
        advance();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h3c1d_0001;
        sample();
        chk("t1_data_ok", inst_data_ok, 1'b1);
        chk("t1_rdata", inst_rdata, 32'h3c1d_0001);
        advance();
        clr();

        // Simultaneous requests: data port wins, inst follows
        dok_cnt = 0; dok_seq = 8'h0;
        inst_req = 1'b1; inst_addr = 32'h0000_1000;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_2000;
        sample();
        chk("t2_data_addr_ok", data_addr_ok, 1'b1);
        chk("t2_inst_addr_ok", inst_addr_ok, 1'b0);
        advance();
        data_req = 1'b0;
        serve(40);
        chk("t2_dok_cnt", dok_cnt, 2);
        chk("t2_order", {30'h0, dok_seq[1:0]}, 32'h2);

        // Byte write, AW accepted two cycles before W
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
        data_addr = 32'h8000_0003; data_wdata = 32'hAB00_0000;
        sample();
        advance();
        clr(); awready = 1'b1;
        sample();
        chk("t3_wstrb", wstrb, 4'b1000);
        advance();
        awready = 1'b0;
        sample();
        chk("t3_aw_dropped", awvalid, 1'b0);
        chk("t3_no_bready", bready, 1'b0);
        advance();
        sample();
        advance();
        wready = 1'b1;
        sample();
        advance();
        wready = 1'b0; bvalid = 1'b1;
        sample();
        chk("t3_bready", bready, 1'b1);
        chk("t3_data_ok", data_data_ok, 1'b1);
        advance();
        clr();

        // AR back-pressure while the data port keeps requesting
        inst_req = 1'b1; inst_addr = 32'h0000_0400;
        sample();
        advance();
        inst_req = 1'b0;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd1; data_addr = 32'h0000_0802;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("t4_araddr", araddr, 32'h0000_0400);
            chk("t4_no_accept", data_addr_ok, 1'b0);
            advance();
        end
        serve(40);

        // Halfword write
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1;
        data_addr = 32'h8000_0002; data_wdata = 32'h1234_0000;
        sample();
        advance();
        data_req = 1'b0;
        sample();
        chk("t5_wstrb", wstrb, 4'b1100);
        chk("t5_awsize", awsize, 3'd1);
        advance();
        serve(40);

        // Reset while waiting for read data
        inst_req = 1'b1; inst_addr = 32'h0000_3000;
        sample();
        advance();
        inst_req = 1'b0; arready = 1'b1;
        sample();
        advance();
        arready = 1'b0; reset = 1'b1;
        sample();
        advance();
        reset = 1'b0;
        sample();
        chk("t6_rready", rready, 1'b0);
        chk("t6_no_dok", inst_data_ok, 1'b0);
        advance();
        dok_cnt = 0;
        inst_req = 1'b1; inst_addr = 32'h0000_0040;
        serve(20);
        chk("t6_fresh_dok", dok_cnt, 1);

        // Random traffic with random slave timing and occasional reset
        pend_i = 1'b0; pend_d = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            if (!pend_i && $urandom_range(0, 3) == 0) begin
                pend_i = 1'b1; inst_addr = $urandom;
            end
            if (!pend_d && $urandom_range(0, 3) == 0) begin
                pend_d = 1'b1; data_wr = 1'($urandom_range(0, 1));
                data_size = 2'($urandom_range(0, 2));
                data_addr = $urandom; data_wdata = $urandom;
            end
            inst_req = pend_i && !reset;
            data_req = pend_d && !reset;
            drive_slave(1'b1);
            sample();
            advance();
            if (acc_i) pend_i = 1'b0;
            if (acc_d) pend_d = 1'b0;
        end
        reset = 1'b0;
        clr();
        serve(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
